// File: rtl/uart_rx_oversample.sv
// UART receiver: 2-flop synchronized rx, DIV-clock oversample tick, mid-bit sampling, LSB first.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx_oversample #(
    parameter int unsigned DIV        = 27,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 R,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy,
    output logic [31:0]          frame_count
);

    localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SmpW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
    localparam logic [SmpW-1:0] SmpLast = SmpW'(OVERSAMPLE - 1);
    localparam logic [SmpW-1:0] SmpMid  = SmpW'(OVERSAMPLE / 2 - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StWaitHigh
    } state_e;

    state_e                 state_q;
    logic                   rx_meta, rx_s;
    logic [DivW-1:0]        div_q;
    logic [SmpW-1:0]        smp_q;
    logic [BitW-1:0]        bit_q;
    logic [DATA_BITS-1:0]   shreg_q;
    logic [DATA_BITS-1:0]   shift_next;
    logic                   tick;
    logic                   at_last;
`ifdef UART_RX_PARITY_EN
    logic                   par_q;
`endif

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign tick       = (div_q == DivLast);
    assign at_last    = tick && (smp_q == SmpLast);
    // Line order is LSB first, so each new bit enters at the MSB and walks down.
    assign shift_next = (shreg_q >> 1) | (DATA_BITS'(rx_s) << (DATA_BITS - 1));

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state_q     <= StIdle;
            div_q       <= '0;
            smp_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            data_out    <= '0;
            valid       <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
            frame_count <= '0;
`ifdef UART_RX_PARITY_EN
            par_q       <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            div_q <= tick ? '0 : div_q + 1'b1;
            if (tick) begin
                smp_q <= (smp_q == SmpLast) ? '0 : smp_q + 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        // Restart the divider so ticks are phased to the start edge.
                        state_q <= StStart;
                        busy    <= 1'b1;
                        div_q   <= '0;
                        smp_q   <= '0;
                    end
                end
                StStart: begin
                    if (tick && (smp_q == SmpMid)) begin
                        smp_q <= '0;
                        if (!rx_s) begin
                            state_q <= StData;
                            bit_q   <= '0;
                        end else begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
                        end
                    end
                end
                StData: begin
                    if (at_last) begin
                        shreg_q <= shift_next;
                        if (bit_q == BitLast) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (at_last) begin
                        par_q   <= rx_s;
                        state_q <= StStop;
                    end
                end
`endif
                StStop: begin
                    if (at_last) begin
                        if (rx_s) begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (^{shreg_q, par_q}) begin
                                parity_err <= 1'b1;
                            end else begin
                                data_out    <= shreg_q;
                                valid       <= 1'b1;
                                frame_count <= frame_count + 32'd1;
                            end
`else
                            data_out    <= shreg_q;
                            valid       <= 1'b1;
                            frame_count <= frame_count + 32'd1;
`endif
                        end else begin
                            frame_err <= 1'b1;
                            state_q   <= StWaitHigh;
                        end
                    end
                end
                StWaitHigh: begin
                    if (rx_s) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Self-checking bench for uart_rx_oversample: directed sequences, a vector table and random frames.
`timescale 1ns/1ps
module tb_uart_rx_oversample;

    localparam int unsigned DIV      = 4;
    localparam int unsigned OS       = 16;
    localparam int unsigned DB       = 8;
    localparam int unsigned BIT_CLKS = DIV * OS;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          R;
    logic          rx;
    logic [DB-1:0] data_out;
    logic          valid;
    logic          frame_err;
    logic          busy;
    logic [31:0]   frame_count;
`ifdef UART_RX_PARITY_EN
    logic          parity_err;
`endif

    always #5 clk = ~clk;

    uart_rx_oversample #(
        .DIV        (DIV),
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB)
    ) dut (
        .clk         (clk),
        .R           (R),
        .rx          (rx),
        .data_out    (data_out),
        .valid       (valid),
        .frame_err   (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err  (parity_err),
`endif
        .busy        (busy),
        .frame_count (frame_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Strobe monitor, sampled on the falling edge.
    int          n_valid = 0, n_ferr = 0, n_perr = 0, viol = 0;
    longint      cyc = 0, valid_cyc = 0, start_cyc = 0;
    logic        pv = 1'b0, pf = 1'b0, pp = 1'b0;
    logic [DB-1:0] got_q[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        logic perr_now;
`ifdef UART_RX_PARITY_EN
        perr_now = parity_err;
`else
        perr_now = 1'b0;
`endif
        if (valid) begin
            n_valid++;
            got_q.push_back(data_out);
            valid_cyc = cyc;
        end
        if (frame_err) n_ferr++;
        if (perr_now) n_perr++;
        if ((valid && frame_err) || (perr_now && (valid || frame_err))) viol++;
        if ((valid && pv) || (frame_err && pf) || (perr_now && pp)) viol++;
        pv = valid;
        pf = frame_err;
        pp = perr_now;
    end

    // Frame-level reference model.
    int unsigned   m_valid = 0, m_ferr = 0, m_perr = 0;
    logic [DB-1:0] m_data  = '0;
    logic [31:0]   m_count = '0;

    task automatic model_frame(input logic [DB-1:0] d, input logic stop, input logic pflip);
        if (!stop) m_ferr++;
        else if (PAR_EN && pflip) m_perr++;
        else begin
            m_valid++;
            m_data  = d;
            m_count = m_count + 32'd1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // Leaves rx at the stop-bit level; the next gap drives it high again.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic pflip,
                              input int gap);
        rx = 1'b1;
        repeat (gap) @(negedge clk);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < int'(DB); i++) drive_bit(d[i]);
        if (PAR_EN) drive_bit(^d ^ pflip);
        drive_bit(stop);
    endtask

    task automatic verify(input string name);
        check({name, "_valid_count"}, n_valid, m_valid);
        check({name, "_ferr_count"}, n_ferr, m_ferr);
        check({name, "_perr_count"}, n_perr, m_perr);
        check({name, "_data_out"}, data_out, m_data);
        check({name, "_frame_count"}, frame_count, m_count);
    endtask

    typedef struct {
        logic [DB-1:0] data;
        logic          stop;
        logic          pflip;
        logic          exp_valid;
        logic          exp_ferr;
        logic          exp_perr;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [DB-1:0] d, input logic s, input logic p,
                           input logic ev, input logic ef, input logic ep);
        vec_t v;
        v.data = d; v.stop = s; v.pflip = p;
        v.exp_valid = ev; v.exp_ferr = ef; v.exp_perr = ep;
        vecs.push_back(v);
    endtask

    initial begin
        int b_valid, b_ferr, b_perr;
        logic [DB-1:0] rd;
        logic          rs, rp;

        add_vec(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add_vec(8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef UART_RX_PARITY_EN
        add_vec(8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        add_vec(8'h07, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
`endif

        R  = 1'b1;
        rx = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_valid", valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_busy", busy, 0);
        check("reset_data_out", data_out, 0);
        check("reset_frame_count", frame_count, 0);
        R = 1'b0;
        repeat (5) @(negedge clk);

        // Single good frame and its latency from the start edge.
        send_frame(8'hA5, 1'b1, 1'b0, 4);
        model_frame(8'hA5, 1'b1, 1'b0);
        verify("a5");
        check("a5_latency_window",
              32'((valid_cyc - start_cyc >= 606) && (valid_cyc - start_cyc <= 614)), 1);

        // Short low glitch: false start, no strobes.
        rx = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch_busy_in_start", busy, 1);
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("glitch_busy_after", busy, 0);
        verify("glitch");

        // Bad stop bit then a stuck-low line.
        send_frame(8'h3C, 1'b0, 1'b0, 4);
        model_frame(8'h3C, 1'b0, 1'b0);
        repeat (200) @(negedge clk);
        check("ferr_busy_while_low", busy, 1);
        verify("ferr");
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("ferr_busy_after_high", busy, 0);
        send_frame(8'h3C, 1'b1, 1'b0, 4);
        model_frame(8'h3C, 1'b1, 1'b0);
        verify("ferr_recover");

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1, 1'b0, 4);
        send_frame(8'hFF, 1'b1, 1'b0, 0);
        model_frame(8'h00, 1'b1, 1'b0);
        model_frame(8'hFF, 1'b1, 1'b0);
        verify("b2b");
        check("b2b_first_word", got_q[got_q.size() - 2], 8'h00);

        // Reset in the middle of the data bits.
        rx = 1'b1;
        repeat (4) @(negedge clk);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        repeat (10) @(negedge clk);
        R  = 1'b1;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_data_out", data_out, 0);
        check("midreset_frame_count", frame_count, 0);
        check("midreset_busy", busy, 0);
        check("midreset_strobes", {valid, frame_err}, 0);
        R       = 1'b0;
        m_data  = '0;
        m_count = '0;
        repeat (12 * BIT_CLKS) @(negedge clk);
        verify("midreset_quiet");
        send_frame(8'h81, 1'b1, 1'b0, 4);
        model_frame(8'h81, 1'b1, 1'b0);
        verify("after_reset");

        // Vector table.
        foreach (vecs[i]) begin
            b_valid = n_valid;
            b_ferr  = n_ferr;
            b_perr  = n_perr;
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].pflip, 8);
            model_frame(vecs[i].data, vecs[i].stop, vecs[i].pflip);
            check($sformatf("vec%0d_valid", i), n_valid - b_valid, 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_ferr", i), n_ferr - b_ferr, 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_perr", i), n_perr - b_perr, 32'(vecs[i].exp_perr));
            check($sformatf("vec%0d_data_out", i), data_out, m_data);
            check($sformatf("vec%0d_frame_count", i), frame_count, m_count);
        end

        // Random frames against the model.
        for (int i = 0; i < 24; i++) begin
            rd = DB'($urandom);
            rs = ($urandom_range(0, 7) != 0);
            rp = PAR_EN ? ($urandom_range(0, 3) == 0) : 1'b0;
            send_frame(rd, rs, rp, int'($urandom_range(4, 40)));
            model_frame(rd, rs, rp);
            check($sformatf("rand%0d_data_out", i), data_out, m_data);
            check($sformatf("rand%0d_frame_count", i), frame_count, m_count);
        end
        rx = 1'b1;
        repeat (8) @(negedge clk);
        verify("rand_final");
        check("strobe_overlap_or_width", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
